// File: rtl/dvp_raw_source.sv
// DVP-style RAW8 RGGB test-pattern source: vsync/href/data frame timing plus
// four selectable patterns, all outputs registered.
module dvp_raw_source #(
  parameter int H_ACTIVE  = 1024,
  parameter int H_BLANK   = 256,
  parameter int V_ACTIVE  = 1024,
  parameter int VSYNC_LEN = 4,
  parameter int V_BP      = 16,
  parameter int V_FP      = 4,
  parameter bit VSYNC_POL = 1'b1,
  parameter int BAR_SHIFT = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       out_vsync,
  output logic       out_href,
  output logic [7:0] out_data,
  output logic       frame_done,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int LINES   = VSYNC_LEN + V_BP + V_ACTIVE + V_FP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(LINES + 1);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_LAST  = VW'(LINES - 1);
  localparam logic [VW-1:0] V_BP0   = VW'(VSYNC_LEN);
  localparam logic [VW-1:0] V_ACT0  = VW'(VSYNC_LEN + V_BP);
  localparam logic [VW-1:0] V_FP0   = VW'(VSYNC_LEN + V_BP + V_ACTIVE);

  // {R,G,B} presence per bar, bar 7 in the top bits.
  localparam logic [23:0] BAR_RGB = {3'b000, 3'b001, 3'b100, 3'b101,
                                     3'b010, 3'b011, 3'b110, 3'b111};

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

  state_t          state, state_n;
  logic [HW-1:0]   h_cnt, h_n;
  logic [VW-1:0]   v_cnt, v_n;
  logic [1:0]      pat_q, pat_n;
  logic [7:0]      frame_val, frame_val_n;
  logic [7:0]      cnt_n, data_n, x8, y8;
  logic [2:0]      bar, rgb;
  logic            vsync_n, href_n, done_n, start, last, chan_on;

  function automatic state_t region(input logic [VW-1:0] v);
    if (v < V_BP0)       return VSYNC;
    else if (v < V_ACT0) return VBP;
    else if (v < V_FP0)  return ACTIVE;
    else                 return VFP;
  endfunction

  // Counters and outputs are computed for the position being entered, so
  // every output is registered alongside the counter that describes it.
  always_comb begin
    state_n     = state;
    h_n         = h_cnt;
    v_n         = v_cnt;
    pat_n       = pat_q;
    frame_val_n = frame_val;
    cnt_n       = frame_cnt;
    done_n      = 1'b0;
    start       = 1'b0;
    last        = (h_cnt == H_LAST) && (v_cnt == V_LAST);

    if (state == IDLE) begin
      start = enable;
    end else if (last) begin
      start   = enable;
      state_n = IDLE;
      h_n     = '0;
      v_n     = '0;
    end else begin
      if (h_cnt == H_LAST) begin
        h_n = '0;
        v_n = v_cnt + 1'b1;
      end else begin
        h_n = h_cnt + 1'b1;
      end
      state_n = region(v_n);
    end

    if (start) begin
      state_n     = VSYNC;
      h_n         = '0;
      v_n         = '0;
      pat_n       = pattern_sel;
      frame_val_n = frame_cnt;
    end

    if (state_n != IDLE && h_n == H_LAST && v_n == V_LAST) begin
      done_n = 1'b1;
      cnt_n  = frame_cnt + 8'd1;
    end

    vsync_n = (state_n == VSYNC) ? VSYNC_POL : ~VSYNC_POL;
    href_n  = (state_n == ACTIVE) && (h_n < H_ACT);

    x8  = 8'(h_n);
    y8  = 8'(v_n - V_ACT0);
    bar = h_n[BAR_SHIFT +: 3];
    rgb = BAR_RGB[3*int'(bar) +: 3];
    if (!y8[0] && !x8[0])     chan_on = rgb[2];
    else if (y8[0] && x8[0])  chan_on = rgb[0];
    else                      chan_on = rgb[1];

    data_n = '0;
    if (href_n) begin
      case (pat_n)
        2'd0:    data_n = chan_on ? 8'hFF : 8'h00;
        2'd1:    data_n = x8;
        2'd2:    data_n = frame_val_n;
        default: data_n = x8 ^ y8;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      h_cnt      <= '0;
      v_cnt      <= '0;
      pat_q      <= '0;
      frame_val  <= '0;
      out_vsync  <= ~VSYNC_POL;
      out_href   <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_n;
      h_cnt      <= h_n;
      v_cnt      <= v_n;
      pat_q      <= pat_n;
      frame_val  <= frame_val_n;
      out_vsync  <= vsync_n;
      out_href   <= href_n;
      out_data   <= data_n;
      frame_done <= done_n;
      frame_cnt  <= cnt_n;
    end
  end

endmodule

// File: tb/tb_dvp_raw_source.sv
// Directed bench for dvp_raw_source in the 16x4 active, 140-clock frame setup.
module tb_dvp_raw_source;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic [1:0] pattern_sel;
  logic       out_vsync;
  logic       out_href;
  logic [7:0] out_data;
  logic       frame_done;
  logic [7:0] frame_cnt;

  int vectors;
  int errors;

  logic       cap_vs   [1:300];
  logic       cap_href [1:300];
  logic       cap_done [1:300];
  logic [7:0] cap_data [1:300];
  logic [7:0] cap_cnt  [1:300];

  dvp_raw_source #(
    .H_ACTIVE(16), .H_BLANK(4), .V_ACTIVE(4), .VSYNC_LEN(1),
    .V_BP(1), .V_FP(1), .VSYNC_POL(1'b1), .BAR_SHIFT(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pattern_sel(pattern_sel),
    .out_vsync(out_vsync), .out_href(out_href), .out_data(out_data),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle c is the period following the c-th rising edge; sampled mid-period.
  task automatic capture(input int first, input int last);
    for (int c = first; c <= last; c++) begin
      @(posedge clk);
      @(negedge clk);
      cap_vs[c]   = out_vsync;
      cap_href[c] = out_href;
      cap_data[c] = out_data;
      cap_done[c] = frame_done;
      cap_cnt[c]  = frame_cnt;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; pattern_sel = 2'd0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({out_vsync, out_href, out_data, frame_done, frame_cnt} !== 19'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b",
               {out_vsync, out_href, out_data, frame_done, frame_cnt}, 19'b0);
    end
    reset_n = 1'b1;
    capture(1, 5);
    vectors++;
    if ({cap_vs[5], cap_href[5], cap_cnt[5]} !== 10'b0) begin
      errors++;
      $display("FAIL idle_without_enable: got %b want %b",
               {cap_vs[5], cap_href[5], cap_cnt[5]}, 10'b0);
    end
  endtask

  task automatic test_ramp_frame();
    int line, h, bursts;
    logic ev, eh, efd;
    logic [7:0] ed, ec;
    enable = 1'b1; pattern_sel = 2'd1;
    capture(1, 141);
    bursts = 0;
    for (int c = 1; c <= 140; c++) begin
      line = (c - 1) / 20;
      h    = (c - 1) % 20;
      ev   = (line == 0);
      eh   = (line >= 2) && (line <= 5) && (h < 16);
      ed   = eh ? 8'(h) : 8'h00;
      efd  = (c == 140);
      ec   = (c == 140) ? 8'd1 : 8'd0;
      if (cap_href[c] && (c == 1 || !cap_href[c-1])) bursts++;
      vectors++;
      if ({cap_vs[c], cap_href[c], cap_data[c], cap_done[c], cap_cnt[c]} !== {ev, eh, ed, efd, ec}) begin
        errors++;
        $display("FAIL ramp_cycle_%0d: got vs=%b href=%b data=%h done=%b cnt=%0d want vs=%b href=%b data=%h done=%b cnt=%0d",
                 c, cap_vs[c], cap_href[c], cap_data[c], cap_done[c], cap_cnt[c], ev, eh, ed, efd, ec);
      end
    end
    vectors++;
    if (bursts != 4) begin
      errors++;
      $display("FAIL href_bursts: got %0d want 4", bursts);
    end
    vectors++;
    if ({cap_vs[141], cap_href[141], cap_done[141], cap_cnt[141]} !== {1'b1, 1'b0, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL next_vsync: got vs=%b href=%b done=%b cnt=%0d want vs=1 href=0 done=0 cnt=1",
               cap_vs[141], cap_href[141], cap_done[141], cap_cnt[141]);
    end
  endtask

  task automatic test_pattern_switch();
    int line, h;
    logic [7:0] ed;
    logic [7:0] row1 [4];
    row1 = '{8'd1, 8'd0, 8'd3, 8'd2};
    pattern_sel = 2'd3;
    capture(2, 140);
    for (int c = 41; c <= 120; c++) begin
      h  = (c - 1) % 20;
      ed = (h < 16) ? 8'(h) : 8'h00;
      vectors++;
      if (cap_data[c] !== ed) begin
        errors++;
        $display("FAIL switch_still_ramp_c%0d: got %h want %h", c, cap_data[c], ed);
      end
    end
    vectors++;
    if ({cap_done[140], cap_cnt[140]} !== {1'b1, 8'd2}) begin
      errors++;
      $display("FAIL switch_frame2_end: got done=%b cnt=%0d want done=1 cnt=2", cap_done[140], cap_cnt[140]);
    end
    capture(1, 140);
    for (int c = 41; c <= 120; c++) begin
      line = (c - 1) / 20;
      h    = (c - 1) % 20;
      ed   = (h < 16) ? (8'(h) ^ 8'(line - 2)) : 8'h00;
      vectors++;
      if (cap_data[c] !== ed) begin
        errors++;
        $display("FAIL xor_c%0d: got %h want %h", c, cap_data[c], ed);
      end
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (cap_data[61 + i] !== row1[i]) begin
        errors++;
        $display("FAIL xor_row1_x%0d: got %h want %h", i, cap_data[61 + i], row1[i]);
      end
    end
    vectors++;
    if (cap_cnt[140] !== 8'd3) begin
      errors++;
      $display("FAIL switch_frame3_cnt: got %0d want 3", cap_cnt[140]);
    end
  endtask

  task automatic test_bars();
    int bx [17];
    int by [17];
    logic [7:0] bv [17];
    int c;
    bx = '{0, 2, 4, 5, 10, 14, 1, 3, 11, 13, 15, 7, 8, 14, 7, 9, 15};
    by = '{0, 0, 0, 0, 0,  0,  1, 1, 1,  1,  1,  2, 2, 2,  3, 3, 3};
    bv = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00,
           8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00};
    pattern_sel = 2'd0;
    capture(1, 140);
    for (int i = 0; i < 17; i++) begin
      c = 41 + by[i] * 20 + bx[i];
      vectors++;
      if ({cap_href[c], cap_data[c]} !== {1'b1, bv[i]}) begin
        errors++;
        $display("FAIL bar_x%0d_y%0d: got href=%b data=%h want href=1 data=%h",
                 bx[i], by[i], cap_href[c], cap_data[c], bv[i]);
      end
    end
    vectors++;
    if ({cap_href[57], cap_data[57]} !== 9'b0) begin
      errors++;
      $display("FAIL bar_blank: got href=%b data=%h want href=0 data=00", cap_href[57], cap_data[57]);
    end
    vectors++;
    if (cap_cnt[140] !== 8'd4) begin
      errors++;
      $display("FAIL bar_frame_cnt: got %0d want 4", cap_cnt[140]);
    end
  endtask

  task automatic test_enable_drop();
    int dones, bad;
    pattern_sel = 2'd1;
    capture(1, 85);
    enable = 1'b0;
    capture(86, 200);
    dones = 0;
    bad = 0;
    for (int c = 1; c <= 200; c++) if (cap_done[c]) dones++;
    for (int c = 141; c <= 200; c++) if (cap_vs[c] || cap_href[c] || cap_data[c] != 8'h00) bad++;
    vectors++;
    if (dones != 1 || cap_done[140] !== 1'b1) begin
      errors++;
      $display("FAIL drop_done_once: got count=%0d at140=%b want count=1 at140=1", dones, cap_done[140]);
    end
    vectors++;
    if ({cap_href[116], cap_data[116]} !== {1'b1, 8'd15}) begin
      errors++;
      $display("FAIL drop_frame_completes: got href=%b data=%h want href=1 data=0f", cap_href[116], cap_data[116]);
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL drop_idle_outputs: got %0d active cycles want 0", bad);
    end
    vectors++;
    if ({cap_cnt[140], cap_cnt[200]} !== {8'd5, 8'd5}) begin
      errors++;
      $display("FAIL drop_cnt_frozen: got %0d,%0d want 5,5", cap_cnt[140], cap_cnt[200]);
    end
  endtask

  task automatic test_reset_midburst();
    enable = 1'b1; pattern_sel = 2'd1;
    capture(1, 50);
    vectors++;
    if ({cap_href[50], cap_data[50], cap_cnt[50]} !== {1'b1, 8'd9, 8'd5}) begin
      errors++;
      $display("FAIL pre_reset_burst: got href=%b data=%h cnt=%0d want href=1 data=09 cnt=5",
               cap_href[50], cap_data[50], cap_cnt[50]);
    end
    #1 reset_n = 1'b0;
    #1;
    vectors++;
    if ({out_vsync, out_href, out_data, frame_done, frame_cnt} !== 19'b0) begin
      errors++;
      $display("FAIL async_reset: got %b want %b",
               {out_vsync, out_href, out_data, frame_done, frame_cnt}, 19'b0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    capture(1, 140);
    vectors++;
    if ({cap_vs[1], cap_vs[20], cap_vs[21], cap_href[40], cap_href[41], cap_data[41], cap_data[56]}
        !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd15}) begin
      errors++;
      $display("FAIL restart_timing: got vs1=%b vs20=%b vs21=%b h40=%b h41=%b d41=%h d56=%h want 1 1 0 0 1 00 0f",
               cap_vs[1], cap_vs[20], cap_vs[21], cap_href[40], cap_href[41], cap_data[41], cap_data[56]);
    end
    vectors++;
    if ({cap_done[139], cap_done[140], cap_cnt[139], cap_cnt[140]} !== {1'b0, 1'b1, 8'd0, 8'd1}) begin
      errors++;
      $display("FAIL restart_end: got done=%b%b cnt=%0d,%0d want done=01 cnt=0,1",
               cap_done[139], cap_done[140], cap_cnt[139], cap_cnt[140]);
    end
  endtask

  task automatic test_frame_count();
    logic [7:0] k8;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    pattern_sel = 2'd2; enable = 1'b1; reset_n = 1'b1;
    for (int k = 0; k <= 256; k++) begin
      k8 = 8'(k);
      capture(1, 140);
      vectors++;
      if ({cap_data[41], cap_data[116], cap_data[57], cap_cnt[140]} !== {k8, k8, 8'h00, 8'(k + 1)}) begin
        errors++;
        $display("FAIL flat_frame_%0d: got d41=%h d116=%h d57=%h cnt=%0d want %h %h 00 %0d",
                 k, cap_data[41], cap_data[116], cap_data[57], cap_cnt[140], k8, k8, 8'(k + 1));
      end
    end
    vectors++;
    if (frame_cnt !== 8'd1) begin
      errors++;
      $display("FAIL frame_cnt_wrap: got %0d want 1", frame_cnt);
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    reset_n = 1'b0;
    enable = 1'b0;
    pattern_sel = 2'd0;
    test_reset();
    test_ramp_frame();
    test_pattern_switch();
    test_bars();
    test_enable_drop();
    test_reset_midburst();
    test_frame_count();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dvp_raw_source.md
Name: dvp_raw_source

Overview:
- Single-clock DVP-style RAW8 Bayer (RGGB) video transmitter: the source side of the camera capture path (vsync/href/8-bit data).
- Drives the ISP input path without the OV5640 in circuit, for bring-up and regression of capture, ISP, DDR frame buffer and HDMI output.
- Generates the frame timing and four selectable test patterns.
- Output signals are registered and are valid on the rising edge of clk. The receiver uses clk as its pixel clock.

Parameters:
- H_ACTIVE, 1024: active pixels per line. Must be a multiple of 8.
- H_BLANK, 256: href-low clocks at the end of every line. Must be at least 1.
- V_ACTIVE, 1024: active lines per frame.
- VSYNC_LEN, 4: lines with vsync asserted. Must be at least 1.
- V_BP, 16: blank lines after vsync and before the first active line.
- V_FP, 4: blank lines after the last active line.
- VSYNC_POL, 1: vsync active level.
- BAR_SHIFT, 7: log2(H_ACTIVE/8). Sets the colour-bar width in pixels.

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run request. Sampled only at frame boundaries.
- pattern_sel  in  2  0 = Bayer colour bars, 1 = horizontal ramp, 2 = flat frame count, 3 = x XOR y.
- out_vsync  out  1  frame sync, polarity set by VSYNC_POL.
- out_href  out  1  line valid.
- out_data  out  8  RAW8 pixel value. Forced to 0 while out_href = 0.
- frame_done  out  1  one-cycle pulse at the end of each frame.
- frame_cnt  out  8  count of completed frames.

Behaviour:
- Reset is asynchronous and active-low; the clock and reset ports are named clk and reset_n.
- Reset values: state IDLE, out_vsync = ~VSYNC_POL, out_href = 0, out_data = 0, frame_done = 0, frame_cnt = 0, all internal counters 0.
- H_TOTAL = H_ACTIVE + H_BLANK.
- LINES = VSYNC_LEN + V_BP + V_ACTIVE + V_FP.
- Frame length is LINES × H_TOTAL clocks.
- Counter h_cnt runs 0..H_TOTAL-1. Line counter v_cnt runs 0..LINES-1 and increments when h_cnt wraps.
- States:
  - IDLE: at a clk edge with enable = 1, go to VSYNC, clear h_cnt and v_cnt, and latch pattern_sel into pat_q.
  - VSYNC: lasts VSYNC_LEN lines. out_vsync = VSYNC_POL for exactly VSYNC_LEN × H_TOTAL cycles, starting with the cycle after the IDLE exit edge.
  - VBP: lasts V_BP lines. Skipped when V_BP = 0.
  - ACTIVE: lasts V_ACTIVE lines. out_href = 1 for h_cnt 0..H_ACTIVE-1, then 0 for H_BLANK cycles.
  - VFP: lasts V_FP lines. On its last cycle:
    - frame_done = 1 for one cycle.
    - frame_cnt increments, wrapping 255 to 0.
    - Next state is VSYNC if enable = 1 (pat_q is re-latched and h_cnt/v_cnt clear), otherwise IDLE.
    - When V_FP = 0, these end-of-frame actions occur on the last cycle of the final ACTIVE line.
- Outputs are registered. out_href and out_data for pixel (x, y) appear in the same cycle, with x = h_cnt and y = active line index.
- pattern_sel and enable have no effect mid-frame. If enable falls mid-frame, the frame completes and the block then stays in IDLE.
- Asserting reset at any point returns every output to its reset value immediately. After release, a new frame starts with VSYNC if enable = 1.
- Pattern 0, Bayer colour bars:
  - Bar index b = x[BAR_SHIFT+2:BAR_SHIFT].
  - Bar colours for b = 0..7: white, yellow, cyan, green, magenta, red, blue, black.
  - Bayer channel: y even and x even = R; y even and x odd = G; y odd and x even = G; y odd and x odd = B.
  - out_data = 8'hFF if the bar contains that channel, else 8'h00.
- Pattern 1: out_data = x[7:0].
- Pattern 2: out_data = frame_cnt value at frame start, held for the whole frame.
- Pattern 3: out_data = x[7:0] ^ y[7:0].

Test Plan:
Small configuration for all scenarios: H_ACTIVE = 16, H_BLANK = 4, V_ACTIVE = 4, VSYNC_LEN = 1, V_BP = 1, V_FP = 1, BAR_SHIFT = 1. Frame length is 140 clocks.

1. Release reset with enable = 1 and pattern_sel = 1 → out_vsync high for cycles 1–20; out_href high for 16 cycles beginning at cycle 41 with data 0..15; 4 href bursts in total; frame_done pulses at cycle 140; frame_cnt = 1; cycle 141 starts the next vsync.
2. pattern_sel = 0, check these pixels:
   - Row 0: x = 0 → FF (white R); x = 2 → FF (yellow R); x = 4 → 00 (cyan R); x = 5 → FF (cyan G).
   - Row 1: x = 11 → 00 (red B); x = 13 → FF (blue B).
   - x = 14/15 on any row → 00 (black).
3. Drop enable during active line 2 → frame completes through VFP with frame_done = 1 once; afterwards out_vsync stays inactive, out_href = 0 and frame_cnt is frozen.
4. Change pattern_sel from 1 to 3 mid-frame → rest of the frame stays a ramp; next frame row 1 is x ^ 1 (1, 0, 3, 2, …).
5. Assert reset_n = 0 during an href burst → out_href, out_data and frame_cnt go to 0 and out_vsync goes inactive without waiting for a clk edge; after release, a full 140-cycle frame restarts from vsync.
6. pattern_sel = 2, run 257 frames → frame k carries data k mod 256; frame 256 carries 0; frame_cnt reads 1 at the end.
